// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: state encoding, reset/halt constants
// and the opcode field helper used to spot HLT.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [3:0]  HALT_OPC = 4'hF;
  localparam logic [15:0] PC_STEP  = 16'h0002;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  function automatic logic [3:0] opcode_of(input logic [15:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/cla_16bit.sv
// 16-bit carry-lookahead adder, modulo 2^16: four 4-bit groups with group-level lookahead.
// Purely combinational; no carry out because callers only need wrap-around arithmetic.
module cla_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum
);

  logic [14:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [2:0]  grp_g;
  logic [2:0]  grp_p;
  logic [3:0]  grp_c;

  assign g = a[14:0] & b[14:0];
  assign p = a ^ b;

  always_comb begin
    grp_g = '0;
    grp_p = '0;
    grp_c = '0;
    c     = '0;
    grp_c[0] = cin;
    // Group generate/propagate feed the lookahead chain across groups 0..2.
    for (int k = 0; k < 3; k++) begin
      grp_p[k] = p[4*k] & p[4*k+1] & p[4*k+2] & p[4*k+3];
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
    end
    for (int k = 0; k < 4; k++) begin
      c[4*k] = grp_c[k];
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
  end

  assign sum = p ^ c;

endmodule

// File: rtl/fetch_sequencer_pc_incr.sv
// Sequential-address adder: pc + 2 modulo 2^16, shared by pc_plus2 and the pc update.
// Combinational, zero latency.
module pc_incr
  import fetch_sequencer_pkg::*;
(
  input  logic [15:0] pc,
  output logic [15:0] pc_next
);

  cla_16bit u_cla (
    .a   (pc),
    .b   (PC_STEP),
    .cin (1'b0),
    .sum (pc_next)
  );

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns pc, one outstanding imem request, hands instructions to decode.
// Latency: 1 cycle reset/fire/redirect to request, imem_valid to instr_valid; decode stalls hold the instruction.
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC = fetch_sequencer_pkg::RESET_PC,
  parameter logic [3:0]  HALT_OPC = fetch_sequencer_pkg::HALT_OPC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_data,
  output logic [15:0] instr_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] pc_curr,
  output logic [15:0] pc_plus2,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        halted
);

  import fetch_sequencer_pkg::*;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] pc_next;
  logic        squash;

  pc_incr u_pc_incr (
    .pc      (pc),
    .pc_next (pc_next)
  );

  assign imem_addr = pc;
  assign pc_curr   = pc;
  assign pc_plus2  = pc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_REQ;
      pc          <= RESET_PC;
      squash      <= 1'b0;
      imem_req    <= 1'b0;
      instr_out   <= 16'h0000;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else if (redirect) begin
      pc          <= redirect_pc;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      case (state)
        ST_REQ: begin
          // A request already on the bus this cycle still returns; squash it.
          if (imem_req) begin
            state    <= ST_WAIT;
            squash   <= 1'b1;
            imem_req <= 1'b0;
          end else begin
            state    <= ST_REQ;
            squash   <= 1'b0;
            imem_req <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (imem_valid) begin
            state    <= ST_REQ;
            squash   <= 1'b0;
            imem_req <= 1'b1;
          end else begin
            squash   <= 1'b1;
          end
        end
        default: begin
          state    <= ST_REQ;
          squash   <= 1'b0;
          imem_req <= 1'b1;
        end
      endcase
    end else begin
      case (state)
        ST_REQ: begin
          // After reset the first REQ cycle only arms the request strobe.
          if (imem_req) begin
            imem_req <= 1'b0;
            state    <= ST_WAIT;
          end else begin
            imem_req <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (imem_valid) begin
            if (squash) begin
              squash   <= 1'b0;
              state    <= ST_REQ;
              imem_req <= 1'b1;
            end else begin
              instr_out   <= imem_data;
              instr_valid <= 1'b1;
              state       <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            if (opcode_of(instr_out) == HALT_OPC) begin
              halted <= 1'b1;
              state  <= ST_HALT;
            end else begin
              pc       <= pc_next;
              state    <= ST_REQ;
              imem_req <= 1'b1;
            end
          end
        end
        default: begin
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: per-cycle vector table plus hand sequences for
// halt, wrap, redirect-with-fire and redirect-in-REQ squash.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid;
  logic [15:0] imem_data;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] pc_curr;
  logic [15:0] pc_plus2;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halted;

  int n_chk;
  int n_fail;
  int mem_lat;

  fetch_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_data   (imem_data),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc_curr     (pc_curr),
    .pc_plus2    (pc_plus2),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_read(input logic [15:0] addr);
    case (addr)
      16'h0010: return 16'hF000;
      16'h0006: return 16'h1234;
      default:  return {4'h1, addr[11:0]};
    endcase
  endfunction

  // Variable-latency instruction memory: response mem_lat cycles after the request cycle.
  initial begin
    logic        pend;
    int          cnt;
    logic [15:0] paddr;
    pend = 1'b0;
    cnt = 0;
    paddr = 16'h0000;
    imem_valid = 1'b0;
    imem_data = 16'h0000;
    forever begin
      @(negedge clk);
      imem_valid = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (cnt <= 1) begin
            imem_valid = 1'b1;
            imem_data = mem_read(paddr);
            pend = 1'b0;
          end else begin
            cnt--;
          end
        end
        if (imem_req) begin
          chk("one_outstanding", {15'd0, pend}, 16'h0000);
          pend = 1'b1;
          cnt = mem_lat;
          paddr = imem_addr;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic exp_cyc(input string tag, input logic req, input logic [15:0] pc,
                         input logic iv, input logic [15:0] iout, input logic h);
    logic [15:0] pc2;
    pc2 = pc + 16'd2;
    chk({tag, ".imem_req"},    {15'd0, imem_req},    {15'd0, req});
    chk({tag, ".imem_addr"},   imem_addr,            pc);
    chk({tag, ".pc_curr"},     pc_curr,              pc);
    chk({tag, ".pc_plus2"},    pc_plus2,             pc2);
    chk({tag, ".instr_valid"}, {15'd0, instr_valid}, {15'd0, iv});
    chk({tag, ".instr_out"},   instr_out,            iout);
    chk({tag, ".halted"},      {15'd0, halted},      {15'd0, h});
  endtask

  typedef struct {
    logic        ready;
    logic        redir;
    logic [15:0] rpc;
    int          lat;
    logic        req;
    logic [15:0] pc;
    logic        iv;
    logic [15:0] iout;
  } vec_t;

  function automatic vec_t mk(input logic ready, input logic redir, input logic [15:0] rpc,
                              input int lat, input logic req, input logic [15:0] pc,
                              input logic iv, input logic [15:0] iout);
    vec_t v;
    v.ready = ready; v.redir = redir; v.rpc = rpc; v.lat = lat;
    v.req = req; v.pc = pc; v.iv = iv; v.iout = iout;
    return v;
  endfunction

  vec_t tbl [24];

  initial begin
    // Inputs applied in a cycle; expected outputs observed in that same cycle.
    tbl[0]  = mk(1, 0, 16'h0000, 1, 1, 16'h0000, 0, 16'h0000);
    tbl[1]  = mk(1, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000);
    tbl[2]  = mk(1, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h1000);
    tbl[3]  = mk(1, 0, 16'h0000, 1, 1, 16'h0002, 0, 16'h1000);
    tbl[4]  = mk(1, 0, 16'h0000, 1, 0, 16'h0002, 0, 16'h1000);
    tbl[5]  = mk(1, 0, 16'h0000, 1, 0, 16'h0002, 1, 16'h1002);
    tbl[6]  = mk(1, 0, 16'h0000, 1, 1, 16'h0004, 0, 16'h1002);
    tbl[7]  = mk(1, 0, 16'h0000, 1, 0, 16'h0004, 0, 16'h1002);
    tbl[8]  = mk(1, 0, 16'h0000, 1, 0, 16'h0004, 1, 16'h1004);
    tbl[9]  = mk(1, 0, 16'h0000, 1, 1, 16'h0006, 0, 16'h1004);
    tbl[10] = mk(0, 0, 16'h0000, 1, 0, 16'h0006, 0, 16'h1004);
    tbl[11] = mk(0, 0, 16'h0000, 1, 0, 16'h0006, 1, 16'h1234);
    tbl[12] = mk(0, 0, 16'h0000, 1, 0, 16'h0006, 1, 16'h1234);
    tbl[13] = mk(0, 0, 16'h0000, 1, 0, 16'h0006, 1, 16'h1234);
    tbl[14] = mk(0, 0, 16'h0000, 1, 0, 16'h0006, 1, 16'h1234);
    tbl[15] = mk(0, 0, 16'h0000, 1, 0, 16'h0006, 1, 16'h1234);
    tbl[16] = mk(1, 0, 16'h0000, 3, 0, 16'h0006, 1, 16'h1234);
    tbl[17] = mk(1, 0, 16'h0000, 3, 1, 16'h0008, 0, 16'h1234);
    tbl[18] = mk(1, 1, 16'h0100, 3, 0, 16'h0008, 0, 16'h1234);
    tbl[19] = mk(1, 0, 16'h0000, 3, 0, 16'h0100, 0, 16'h1234);
    tbl[20] = mk(1, 0, 16'h0000, 1, 0, 16'h0100, 0, 16'h1234);
    tbl[21] = mk(1, 0, 16'h0000, 1, 1, 16'h0100, 0, 16'h1234);
    tbl[22] = mk(1, 0, 16'h0000, 1, 0, 16'h0100, 0, 16'h1234);
    tbl[23] = mk(0, 0, 16'h0000, 1, 0, 16'h0100, 1, 16'h1100);

    n_chk = 0;
    n_fail = 0;
    mem_lat = 1;
    rst_n = 1'b0;
    instr_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = 16'h0000;

    tick();
    tick();
    exp_cyc("reset", 0, 16'h0000, 0, 16'h0000, 0);
    rst_n = 1'b1;
    instr_ready = 1'b1;

    for (int i = 0; i < 24; i++) begin
      tick();
      exp_cyc($sformatf("vec%0d", i), tbl[i].req, tbl[i].pc, tbl[i].iv, tbl[i].iout, 1'b0);
      instr_ready = tbl[i].ready;
      redirect = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
      mem_lat = tbl[i].lat;
    end

    // HLT fetched at 0x0010 stops fetch until a redirect.
    tick();
    exp_cyc("hlt_pre", 0, 16'h0100, 1, 16'h1100, 0);
    redirect = 1'b1; redirect_pc = 16'h0010;
    tick();
    exp_cyc("hlt_req", 1, 16'h0010, 0, 16'h1100, 0);
    redirect = 1'b0;
    tick();
    exp_cyc("hlt_wait", 0, 16'h0010, 0, 16'h1100, 0);
    tick();
    exp_cyc("hlt_hold", 0, 16'h0010, 1, 16'hF000, 0);
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_cyc($sformatf("halted%0d", i), 0, 16'h0010, 0, 16'hF000, 1);
    end
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    exp_cyc("unhalt_req", 1, 16'h0040, 0, 16'hF000, 0);
    redirect = 1'b0; instr_ready = 1'b0;
    tick();
    tick();
    exp_cyc("unhalt_hold", 0, 16'h0040, 1, 16'h1040, 0);

    // pc wrap from 0xFFFE.
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    exp_cyc("wrap_req", 1, 16'hFFFE, 0, 16'h1040, 0);
    redirect = 1'b0;
    tick();
    tick();
    exp_cyc("wrap_hold", 0, 16'hFFFE, 1, 16'h1FFE, 0);
    instr_ready = 1'b1;
    tick();
    exp_cyc("wrap_next", 1, 16'h0000, 0, 16'h1FFE, 0);
    instr_ready = 1'b0;
    tick();
    tick();
    exp_cyc("wrap_hold2", 0, 16'h0000, 1, 16'h1000, 0);

    // Redirect coincident with a fire at 0x0020: target wins.
    redirect = 1'b1; redirect_pc = 16'h0020;
    tick();
    exp_cyc("rf_req", 1, 16'h0020, 0, 16'h1000, 0);
    redirect = 1'b0;
    tick();
    tick();
    exp_cyc("rf_hold", 0, 16'h0020, 1, 16'h1020, 0);
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0080;
    tick();
    exp_cyc("rf_target", 1, 16'h0080, 0, 16'h1020, 0);

    // Redirect while the REQ strobe is out: that response is squashed.
    instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 16'h0200;
    tick();
    exp_cyc("sq_wait", 0, 16'h0200, 0, 16'h1020, 0);
    chk("sq_resp_seen", {15'd0, imem_valid}, 16'h0001);
    redirect = 1'b0;
    tick();
    exp_cyc("sq_req", 1, 16'h0200, 0, 16'h1020, 0);
    tick();
    tick();
    exp_cyc("sq_hold", 0, 16'h0200, 1, 16'h1200, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the architectural PC register and sequences instruction fetch for the 16-bit core.
- Issues one request at a time to instruction memory, which has variable latency and returns exactly one response per request.
- Presents each fetched instruction to decode through a valid/ready handshake.
- Applies branch redirects from the branch-resolution logic and stops fetching on HLT.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
HALT_OPC, 4'hF, opcode (instr[15:12]) that halts fetch.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  reset; asynchronous, active-low.
imem_req  out  1  fetch request strobe, one cycle per request.
imem_addr  out  16  fetch address; equals pc while imem_req=1.
imem_valid  in  1  response strobe for the outstanding request.
imem_data  in  16  instruction word; sampled when imem_valid=1.
instr_out  out  16  instruction presented to decode.
instr_valid  out  1  instr_out holds a live instruction.
instr_ready  in  1  decode accepts; a fire occurs when instr_valid & instr_ready.
pc_curr  out  16  address of instr_out.
pc_plus2  out  16  pc_curr+2 (the sequential address used by the branch-target adder).
redirect  in  1  taken-branch pulse from branch resolution.
redirect_pc  in  16  branch target; sampled when redirect=1.
halted  out  1  fetch stopped on HLT.

Behaviour:
- Reset (asynchronous, rst_n=0) sets:
  - pc=RESET_PC, state=REQ, squash=0;
  - imem_req=0, instr_out=16'h0000, instr_valid=0, halted=0.
- States and transitions:
  - REQ: drive imem_req=1, imem_addr=pc for one cycle, then go to WAIT.
  - WAIT: hold imem_req=0 until imem_valid=1.
    - On imem_valid with squash=0: capture instr_out=imem_data, instr_valid=1, go to HOLD.
    - On imem_valid with squash=1: discard the data, clear squash, go to REQ. pc already holds the redirect target.
  - HOLD: instr_valid=1; instr_out and pc_curr stay stable until a fire.
    - On fire with instr_out[15:12]==HALT_OPC: instr_valid=0, halted=1, go to HALT. pc is not advanced.
    - On any other fire: pc=pc+2, instr_valid=0, go to REQ.
  - HALT: no requests are issued; halted=1. Only a redirect or reset leaves this state.
- Redirect (highest priority, applies in every state):
  - pc=redirect_pc, instr_valid=0 in the next cycle, halted=0.
  - From HOLD, HALT or REQ: go to REQ.
  - REQ itself: if the REQ cycle's request was issued in the same cycle as the redirect, that request is still counted as outstanding. Go to WAIT with squash=1.
  - From WAIT: stay in WAIT and set squash=1. If imem_valid arrives in the same cycle, it is the squashed response: drop it, clear squash and go to REQ.
  - Redirect in the same cycle as a fire: the redirect wins, and the fired instruction is still consumed by decode.
  - Redirect in HALT: halt is cancelled, so a speculatively fetched HLT is undone.
- Arithmetic:
  - pc+2 is modulo 2^16; 16'hFFFE wraps to 16'h0000.
  - redirect_pc is taken verbatim, with no alignment check.
- Latency:
  - Reset to first imem_req: 1 cycle.
  - Fire to next imem_req: 1 cycle.
  - imem_valid to instr_valid: 1 cycle.
  - Redirect to request at target: 1 cycle when idle or holding; in WAIT, 1 cycle after the squashed response returns.
- Invariants:
  - At most one outstanding request.
  - imem_req is never asserted in WAIT, HOLD or HALT.
  - pc_curr=pc at all times; pc_plus2=pc+2, combinational.
- Reset mid-operation: an outstanding response that arrives after reset is released is a memory-side responsibility. The sequencer ignores imem_valid in REQ, HOLD and HALT.

Decomposition:
- Shared package holds:
  - state encoding: REQ, WAIT, HOLD, HALT, 2-bit;
  - HALT_OPC;
  - RESET_PC;
  - the opcode field slice [15:12].
- One sub-module, pc_incr: a 16-bit +2 adder built on the existing cla_16bit. It drives both pc_plus2 and the pc update.

Test Plan:
- Reset, memory at 1-cycle latency, instr_ready=1, instructions at 0x0000/0x0002/0x0004 -> imem_addr sequence 0x0000, 0x0002, 0x0004; one fire every 3 cycles; pc_curr matches each fire.
- instr_ready=0 for 5 cycles while holding 16'h1234 -> instr_out, instr_valid and pc_curr stable; no imem_req; fetch resumes 1 cycle after ready rises.
- Redirect to 0x0100 during WAIT with the response 3 cycles late -> the late data never appears on instr_out; next imem_addr=0x0100; halted=0.
- Fetch 16'hF000 at 0x0010 and fire -> halted=1, no further imem_req, pc_curr=0x0010; then redirect to 0x0040 -> halted=0, imem_addr=0x0040 next cycle.
- pc at 16'hFFFE, fire of a non-HLT instruction -> next imem_addr=16'h0000.
- Redirect in the same cycle as a fire at 0x0020 -> next request is to the target, not 0x0022.
